// File: rtl/operand_fetch_pkg.sv
// -----------------------------------------------------------------------------
// operand_fetch_pkg
// Shared instruction-field layout and datapath types for the operand fetch
// and execute stages. Field positions live only here so that every stage
// decodes register indices identically.
// -----------------------------------------------------------------------------
package operand_fetch_pkg;

    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    // Instruction field positions (RISC-V base encoding).
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;

    typedef logic [XLEN-1:0]      word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Contents of the operand fetch -> ALU pipeline register.
    typedef struct packed {
        word_t instruction;
        word_t pc;
        word_t op_a;
        word_t op_b;
    } fetch_slot_t;

    function automatic reg_idx_t rs1_of(input word_t instr);
        return instr[RS1_MSB:RS1_LSB];
    endfunction

    function automatic reg_idx_t rs2_of(input word_t instr);
        return instr[RS2_MSB:RS2_LSB];
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// -----------------------------------------------------------------------------
// operand_fetch_if
// Bundles the operand fetch stage's bus signals:
//   upstream  : in_valid, in_ready, in_instruction, in_pc
//   downstream: out_valid, out_ready, out_instruction, out_pc, out_op_a, out_op_b
//   writeback : wb_en, wb_rd, wb_data
//   control   : flush (branch redirect)
// Modport slave is the operand fetch stage, master is its environment.
// -----------------------------------------------------------------------------
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic     in_valid;
    logic     in_ready;
    word_t    in_instruction;
    word_t    in_pc;

    logic     out_valid;
    logic     out_ready;
    word_t    out_instruction;
    word_t    out_pc;
    word_t    out_op_a;
    word_t    out_op_b;

    logic     wb_en;
    reg_idx_t wb_rd;
    word_t    wb_data;

    logic     flush;

    modport slave (
        input  in_valid, in_instruction, in_pc,
        input  out_ready,
        input  wb_en, wb_rd, wb_data,
        input  flush,
        output in_ready,
        output out_valid, out_instruction, out_pc, out_op_a, out_op_b
    );

    modport master (
        output in_valid, in_instruction, in_pc,
        output out_ready,
        output wb_en, wb_rd, wb_data,
        output flush,
        input  in_ready,
        input  out_valid, out_instruction, out_pc, out_op_a, out_op_b
    );

endinterface

// File: rtl/operand_fetch_reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// 32 x 32-bit integer register file with x0 hardwired to zero.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (clears all regs)
//   raddr_a / rdata_a : combinational read port A
//   raddr_b / rdata_b : combinational read port B
//   we, waddr, wdata  : synchronous write port; writes to x0 are dropped
// -----------------------------------------------------------------------------
module reg_file
    import operand_fetch_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  reg_idx_t raddr_a,
    output word_t    rdata_a,
    input  reg_idx_t raddr_b,
    output word_t    rdata_b,
    input  logic     we,
    input  reg_idx_t waddr,
    input  word_t    wdata
);

    word_t regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: memory arrays are normally left unreset, but this file
            // must read all-zero while rst_n is low, so every entry is cleared.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            // NOTE: sequential state uses <= so all flops sample pre-edge values.
            regs[waddr] <= wdata;
        end
    end

    // x0 is forced to zero at the read mux rather than relying on storage.
    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
// Reads source operands for a decoded instruction and hands the instruction,
// its pc and both operands to the ALU stage through a one-entry pipeline
// register with valid/ready flow control.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : operand_fetch_if.slave (upstream, downstream, writeback, flush)
// Behaviour:
//   - operands captured on transfer, with same-edge writeback bypass
//   - while stalled, writebacks to the held rs1/rs2 refresh the held operands
//   - flush empties the stage and blocks new transfers for that cycle
// -----------------------------------------------------------------------------
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    operand_fetch_if.slave  bus
);

    reg_idx_t    in_rs1;
    reg_idx_t    in_rs2;
    reg_idx_t    held_rs1;
    reg_idx_t    held_rs2;
    word_t       rf_rdata_a;
    word_t       rf_rdata_b;
    word_t       fwd_a;
    word_t       fwd_b;
    logic        wb_live;
    logic        transfer;
    logic        valid_q;
    fetch_slot_t slot_q;

    assign in_rs1   = rs1_of(bus.in_instruction);
    assign in_rs2   = rs2_of(bus.in_instruction);
    assign held_rs1 = rs1_of(slot_q.instruction);
    assign held_rs2 = rs2_of(slot_q.instruction);

    // A writeback that actually changes architectural state (x0 never does).
    assign wb_live  = bus.wb_en && (bus.wb_rd != '0);

    assign bus.in_ready = !bus.flush && (!valid_q || bus.out_ready);
    assign transfer     = bus.in_valid && bus.in_ready;

    reg_file u_reg_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (in_rs1),
        .rdata_a (rf_rdata_a),
        .raddr_b (in_rs2),
        .rdata_b (rf_rdata_b),
        .we      (bus.wb_en),
        .waddr   (bus.wb_rd),
        .wdata   (bus.wb_data)
    );

    // Same-edge bypass: the register file write lands on this edge too, so
    // the read port still shows the stale value.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        fwd_a = rf_rdata_a;
        fwd_b = rf_rdata_b;
        if (wb_live && bus.wb_rd == in_rs1) fwd_a = bus.wb_data;
        if (wb_live && bus.wb_rd == in_rs2) fwd_b = bus.wb_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            slot_q  <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (transfer) begin
            valid_q            <= 1'b1;
            slot_q.instruction <= bus.in_instruction;
            slot_q.pc          <= bus.in_pc;
            slot_q.op_a        <= fwd_a;
            slot_q.op_b        <= fwd_b;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end else if (valid_q) begin
            // Stalled: keep held operands coherent with the register file.
            if (wb_live && bus.wb_rd == held_rs1) slot_q.op_a <= bus.wb_data;
            if (wb_live && bus.wb_rd == held_rs2) slot_q.op_b <= bus.wb_data;
        end
    end

    assign bus.out_valid       = valid_q;
    assign bus.out_instruction = slot_q.instruction;
    assign bus.out_pc          = slot_q.pc;
    assign bus.out_op_a        = slot_q.op_a;
    assign bus.out_op_b        = slot_q.op_b;

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
// Self-checking bench for operand_fetch. The reference model tracks the
// architectural register file and the instruction occupying the stage; while
// the stage is valid its operands must equal the current architectural value
// of the held source registers.
// -----------------------------------------------------------------------------
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    operand_fetch_if ifc ();

    operand_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic  m_valid;
    word_t m_instr;
    word_t m_pc;
    word_t m_regs [32];

    function automatic word_t make_r(input int rd, input int rs1, input int rs2);
        word_t w;
        w = 32'h0000_0033;
        w[11:7]  = rd[4:0];
        w[19:15] = rs1[4:0];
        w[24:20] = rs2[4:0];
        return w;
    endfunction

    function automatic logic model_ready();
        return !ifc.flush && (!m_valid || ifc.out_ready);
    endfunction

    function automatic word_t exp_op_a();
        return m_regs[m_instr[19:15]];
    endfunction

    function automatic word_t exp_op_b();
        return m_regs[m_instr[24:20]];
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_instr = '0;
        m_pc    = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    // Advance the model by the upcoming rising edge using current inputs.
    task automatic model_edge();
        logic rdy;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rdy = model_ready();
        if (ifc.flush) m_valid = 1'b0;
        else if (ifc.in_valid && rdy) begin
            m_valid = 1'b1;
            m_instr = ifc.in_instruction;
            m_pc    = ifc.in_pc;
        end else if (ifc.out_ready) m_valid = 1'b0;
        if (ifc.wb_en && ifc.wb_rd != 5'd0) m_regs[ifc.wb_rd] = ifc.wb_data;
    endtask

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        ifc.in_valid       = 1'b0;
        ifc.in_instruction = '0;
        ifc.in_pc          = '0;
        ifc.out_ready      = 1'b1;
        ifc.wb_en          = 1'b0;
        ifc.wb_rd          = '0;
        ifc.wb_data        = '0;
        ifc.flush          = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        model_reset();
        ifc.in_valid       = 1'b1;
        ifc.in_instruction = 32'h005280B3;
        ifc.in_pc          = 32'h0000_0F00;
        #1;
        n_checks++; if (ifc.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", ifc.out_valid); else n_pass++;
        n_checks++; if (ifc.out_instruction !== 32'h0) $display("FAIL rst_instr: got %h want 0", ifc.out_instruction); else n_pass++;
        n_checks++; if (ifc.out_pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", ifc.out_pc); else n_pass++;
        n_checks++; if (ifc.out_op_a !== 32'h0) $display("FAIL rst_op_a: got %h want 0", ifc.out_op_a); else n_pass++;
        n_checks++; if (ifc.out_op_b !== 32'h0) $display("FAIL rst_op_b: got %h want 0", ifc.out_op_b); else n_pass++;
        n_checks++; if (ifc.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", ifc.in_ready); else n_pass++;
        step();
        n_checks++; if (ifc.out_valid !== 1'b0) $display("FAIL rst_no_transfer: got %b want 0", ifc.out_valid); else n_pass++;
        rst_n = 1'b1;
        set_idle();
        step();
    endtask

    task automatic test_basic();
        ifc.wb_en = 1'b1; ifc.wb_rd = 5'd5; ifc.wb_data = 32'h0000_1234;
        step();
        ifc.wb_en = 1'b0;
        ifc.in_valid = 1'b1; ifc.in_instruction = 32'h005280B3; ifc.in_pc = 32'h0000_1000;
        #1;
        n_checks++; if (ifc.in_ready !== 1'b1) $display("FAIL basic_in_ready: got %b want 1", ifc.in_ready); else n_pass++;
        step();
        ifc.in_valid = 1'b0;
        n_checks++; if (ifc.out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", ifc.out_valid); else n_pass++;
        n_checks++; if (ifc.out_op_a !== 32'h0000_1234) $display("FAIL basic_op_a: got %h want 00001234", ifc.out_op_a); else n_pass++;
        n_checks++; if (ifc.out_op_b !== 32'h0000_1234) $display("FAIL basic_op_b: got %h want 00001234", ifc.out_op_b); else n_pass++;
        n_checks++; if (ifc.out_instruction !== 32'h005280B3) $display("FAIL basic_instr: got %h want 005280b3", ifc.out_instruction); else n_pass++;
        n_checks++; if (ifc.out_pc !== 32'h0000_1000) $display("FAIL basic_pc: got %h want 00001000", ifc.out_pc); else n_pass++;
        step();
        n_checks++; if (ifc.out_valid !== 1'b0) $display("FAIL basic_drain: got %b want 0", ifc.out_valid); else n_pass++;
    endtask

    task automatic test_bypass();
        ifc.in_valid = 1'b1; ifc.in_instruction = make_r(7, 6, 0); ifc.in_pc = 32'h0000_2000;
        ifc.wb_en = 1'b1; ifc.wb_rd = 5'd6; ifc.wb_data = 32'hDEAD_BEEF;
        step();
        n_checks++; if (ifc.out_op_a !== 32'hDEAD_BEEF) $display("FAIL bypass_op_a: got %h want deadbeef", ifc.out_op_a); else n_pass++;
        n_checks++; if (ifc.out_op_b !== 32'h0) $display("FAIL bypass_x0_op_b: got %h want 0", ifc.out_op_b); else n_pass++;
        ifc.in_instruction = make_r(7, 0, 6); ifc.in_pc = 32'h0000_2004;
        ifc.wb_rd = 5'd0; ifc.wb_data = 32'hFFFF_FFFF;
        step();
        n_checks++; if (ifc.out_valid !== 1'b1) $display("FAIL bypass_valid: got %b want 1", ifc.out_valid); else n_pass++;
        n_checks++; if (ifc.out_op_a !== 32'h0) $display("FAIL bypass_wb_x0: got %h want 0", ifc.out_op_a); else n_pass++;
        n_checks++; if (ifc.out_op_b !== 32'hDEAD_BEEF) $display("FAIL bypass_stored: got %h want deadbeef", ifc.out_op_b); else n_pass++;
        set_idle();
        step();
    endtask

    task automatic test_hold_snoop();
        word_t held;
        held = make_r(3, 1, 2);
        ifc.in_valid = 1'b1; ifc.in_instruction = held; ifc.in_pc = 32'h0000_3000;
        step();
        ifc.out_ready = 1'b0;
        ifc.in_instruction = make_r(9, 8, 8); ifc.in_pc = 32'h0000_3004;
        for (int i = 0; i < 3; i++) begin
            ifc.wb_en = (i == 1); ifc.wb_rd = 5'd2; ifc.wb_data = 32'h0000_0005;
            #1;
            n_checks++; if (ifc.in_ready !== 1'b0) $display("FAIL hold_in_ready[%0d]: got %b want 0", i, ifc.in_ready); else n_pass++;
            step();
            n_checks++; if (ifc.out_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %b want 1", i, ifc.out_valid); else n_pass++;
            n_checks++; if (ifc.out_instruction !== held) $display("FAIL hold_instr[%0d]: got %h want %h", i, ifc.out_instruction, held); else n_pass++;
            n_checks++; if (ifc.out_pc !== 32'h0000_3000) $display("FAIL hold_pc[%0d]: got %h want 00003000", i, ifc.out_pc); else n_pass++;
        end
        n_checks++; if (ifc.out_op_b !== 32'h0000_0005) $display("FAIL snoop_op_b: got %h want 00000005", ifc.out_op_b); else n_pass++;
        n_checks++; if (ifc.out_op_a !== exp_op_a()) $display("FAIL snoop_op_a: got %h want %h", ifc.out_op_a, exp_op_a()); else n_pass++;
        set_idle();
        step();
        n_checks++; if (ifc.out_valid !== 1'b0) $display("FAIL hold_release: got %b want 0", ifc.out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        word_t instrs [4];
        for (int i = 0; i < 4; i++) instrs[i] = make_r(i + 1, $urandom_range(0, 7), $urandom_range(0, 7));
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifc.in_valid = 1'b1; ifc.in_instruction = instrs[i]; ifc.in_pc = 32'h0000_4000 + 32'(4 * i);
            #1;
            n_checks++; if (ifc.in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, ifc.in_ready); else n_pass++;
            step();
            n_checks++; if (ifc.out_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", i, ifc.out_valid); else n_pass++;
            n_checks++; if (ifc.out_pc !== 32'h0000_4000 + 32'(4 * i)) $display("FAIL b2b_pc[%0d]: got %h want %h", i, ifc.out_pc, 32'h0000_4000 + 32'(4 * i)); else n_pass++;
            n_checks++; if (ifc.out_instruction !== instrs[i]) $display("FAIL b2b_instr[%0d]: got %h want %h", i, ifc.out_instruction, instrs[i]); else n_pass++;
        end
        set_idle();
        step();
        n_checks++; if (ifc.out_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", ifc.out_valid); else n_pass++;
    endtask

    task automatic test_flush();
        ifc.in_valid = 1'b1; ifc.in_instruction = make_r(1, 3, 4); ifc.in_pc = 32'h0000_5000;
        step();
        ifc.out_ready = 1'b0;
        ifc.in_instruction = make_r(1, 3, 4); ifc.in_pc = 32'h0000_5004;
        ifc.flush = 1'b1;
        ifc.wb_en = 1'b1; ifc.wb_rd = 5'd4; ifc.wb_data = 32'h0000_0044;
        #1;
        n_checks++; if (ifc.in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", ifc.in_ready); else n_pass++;
        step();
        n_checks++; if (ifc.out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", ifc.out_valid); else n_pass++;
        set_idle();
        ifc.wb_en = 1'b1; ifc.wb_rd = 5'd3; ifc.wb_data = 32'h0000_0ABC;
        step();
        n_checks++; if (ifc.out_valid !== 1'b0) $display("FAIL flush_no_transfer: got %b want 0", ifc.out_valid); else n_pass++;
        set_idle();
        ifc.in_valid = 1'b1; ifc.in_instruction = make_r(1, 3, 4); ifc.in_pc = 32'h0000_5008;
        step();
        n_checks++; if (ifc.out_pc !== 32'h0000_5008) $display("FAIL flush_next_pc: got %h want 00005008", ifc.out_pc); else n_pass++;
        n_checks++; if (ifc.out_op_a !== 32'h0000_0ABC) $display("FAIL flush_later_wb: got %h want 00000abc", ifc.out_op_a); else n_pass++;
        n_checks++; if (ifc.out_op_b !== 32'h0000_0044) $display("FAIL flush_edge_wb: got %h want 00000044", ifc.out_op_b); else n_pass++;
        set_idle();
        step();
    endtask

    task automatic test_reset_mid_hold();
        ifc.wb_en = 1'b1; ifc.wb_rd = 5'd5; ifc.wb_data = 32'h0000_0055;
        step();
        ifc.wb_rd = 5'd6; ifc.wb_data = 32'h0000_0066;
        step();
        set_idle();
        ifc.in_valid = 1'b1; ifc.in_instruction = make_r(1, 5, 6); ifc.in_pc = 32'h0000_6000;
        step();
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
        step();
        n_checks++; if (ifc.out_op_a !== 32'h0000_0055) $display("FAIL rmh_pre_op_a: got %h want 00000055", ifc.out_op_a); else n_pass++;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (ifc.out_valid !== 1'b0) $display("FAIL rmh_valid: got %b want 0", ifc.out_valid); else n_pass++;
        n_checks++; if (ifc.out_instruction !== 32'h0) $display("FAIL rmh_instr: got %h want 0", ifc.out_instruction); else n_pass++;
        n_checks++; if (ifc.out_op_b !== 32'h0) $display("FAIL rmh_op_b: got %h want 0", ifc.out_op_b); else n_pass++;
        n_checks++; if (ifc.in_ready !== 1'b1) $display("FAIL rmh_in_ready: got %b want 1", ifc.in_ready); else n_pass++;
        ifc.in_valid = 1'b1; ifc.in_instruction = make_r(1, 5, 6); ifc.in_pc = 32'h0000_6004;
        step();
        n_checks++; if (ifc.out_valid !== 1'b0) $display("FAIL rmh_no_transfer: got %b want 0", ifc.out_valid); else n_pass++;
        rst_n = 1'b1;
        ifc.out_ready = 1'b1;
        step();
        n_checks++; if (ifc.out_valid !== 1'b1) $display("FAIL rmh_fresh_valid: got %b want 1", ifc.out_valid); else n_pass++;
        n_checks++; if (ifc.out_pc !== 32'h0000_6004) $display("FAIL rmh_fresh_pc: got %h want 00006004", ifc.out_pc); else n_pass++;
        n_checks++; if (ifc.out_op_a !== 32'h0) $display("FAIL rmh_fresh_op_a: got %h want 0", ifc.out_op_a); else n_pass++;
        n_checks++; if (ifc.out_op_b !== 32'h0) $display("FAIL rmh_fresh_op_b: got %h want 0", ifc.out_op_b); else n_pass++;
        set_idle();
        step();
    endtask

    task automatic test_random();
        word_t instr;
        for (int i = 0; i < 400; i++) begin
            instr          = $urandom;
            instr[19:15]   = 5'($urandom_range(0, 7));
            instr[24:20]   = 5'($urandom_range(0, 7));
            ifc.in_valid       = ($urandom_range(0, 3) != 0);
            ifc.in_instruction = instr;
            ifc.in_pc          = $urandom;
            ifc.out_ready      = ($urandom_range(0, 3) != 0);
            ifc.flush          = ($urandom_range(0, 15) == 0);
            ifc.wb_en          = ($urandom_range(0, 1) == 1);
            ifc.wb_rd          = 5'($urandom_range(0, 7));
            ifc.wb_data        = $urandom;
            #1;
            n_checks++; if (ifc.in_ready !== model_ready()) $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, ifc.in_ready, model_ready()); else n_pass++;
            step();
            n_checks++; if (ifc.out_valid !== m_valid) $display("FAIL rnd_valid[%0d]: got %b want %b", i, ifc.out_valid, m_valid); else n_pass++;
            if (m_valid) begin
                n_checks++; if (ifc.out_instruction !== m_instr) $display("FAIL rnd_instr[%0d]: got %h want %h", i, ifc.out_instruction, m_instr); else n_pass++;
                n_checks++; if (ifc.out_pc !== m_pc) $display("FAIL rnd_pc[%0d]: got %h want %h", i, ifc.out_pc, m_pc); else n_pass++;
                n_checks++; if (ifc.out_op_a !== exp_op_a()) $display("FAIL rnd_op_a[%0d]: got %h want %h", i, ifc.out_op_a, exp_op_a()); else n_pass++;
                n_checks++; if (ifc.out_op_b !== exp_op_b()) $display("FAIL rnd_op_b[%0d]: got %h want %h", i, ifc.out_op_b, exp_op_b()); else n_pass++;
            end
        end
        set_idle();
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_hold_snoop();
        test_back_to_back();
        test_flush();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
